ppu_ofmap_packer: RTL
=====================

# ppu_ofmap_packer

Output-side packing stage placed directly downstream of the post-processing unit. Collects the stream of quantized 8-bit activations (one byte per valid cycle), packs four bytes into one 32-bit word, buffers the words in a small FIFO, and writes them to the output global buffer at consecutive byte addresses through a valid/ready write port. It also provides backpressure to the controller, a flush path for a trailing partial word, and a completion pulse.

## Interface
- DEPTH, 4, number of 32-bit entries in the word FIFO; power of two, at least 2.
- ADDR_W, 32, width of the GLB byte address.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; asynchronous, active-high.
- start  in  1  one-cycle pulse; latches base_addr and begins a new tile; accepted only in IDLE.
- base_addr  in  ADDR_W  byte address of the first output word; must be 4-byte aligned.
- flush  in  1  one-cycle pulse; end of tile; accepted only in PACK.
- i_valid  in  1  upstream byte valid (the PPU's valid output).
- i_data  in  8  upstream quantized byte.
- in_ready  out  1  upstream may issue bytes; gates the PE/PPU enable.
- glb_wen  out  1  write request, held high while the FIFO is non-empty.
- glb_addr  out  ADDR_W  byte address of the head word.
- glb_wdata  out  32  head word.
- glb_bweb  out  4  byte write enables, bit k covers glb_wdata[8k+7:8k]; present only with PACKER_BYTE_MASK_EN.
- glb_ready  in  1  GLB accepts the write this cycle.
- done  out  1  one-cycle pulse when the tile is fully written.
- overflow  out  1  sticky; a completed word was dropped because the FIFO was full.
- words_written  out  16  count of GLB transfers since the last start.

## Operation
- States: IDLE, PACK, FLUSH, DONE.
  - IDLE, on start: go to PACK, load addr=base_addr, clear byte index, words_written and overflow.
  - PACK, on flush: go to FLUSH.
  - FLUSH: go to DONE once no partial word remains, the FIFO is empty, and no transfer is in progress.
  - DONE: assert done for one cycle, then go to IDLE.
- Packing: bytes are accepted only in PACK when i_valid=1. They are packed little-endian: the first byte goes to [7:0] and the fourth to [31:24]. A 2-bit byte index wraps 3→0. When the fourth byte is accepted, the word is pushed into the FIFO.
- Push succeeds if the FIFO count is less than DEPTH, or if a pop happens in the same cycle. Otherwise the word is dropped and overflow is set. overflow clears only on start or rst.
- In IDLE, FLUSH and DONE, i_valid is ignored.
- in_ready = (state==PACK) && (count < DEPTH-1). This leaves one slot of slack for the registered PPU output.
- Write port: glb_wen = FIFO non-empty. glb_wdata and glb_addr come from the head entry. A transfer occurs when glb_wen && glb_ready. On each transfer: pop, addr += 4 (wrapping modulo 2^ADDR_W), words_written += 1 (saturating at 16'hFFFF).
- glb_wdata and glb_addr hold stable while glb_wen is high and glb_ready is low.
- Flush with byte index n>0: the partial word is pushed as soon as the FIFO has space (same push rule), then the index clears. With n=0 nothing extra is pushed.
- start outside IDLE and flush outside PACK are ignored.

## Timing
- Reset values: in_ready=0, glb_wen=0, glb_addr=0, glb_wdata=0, glb_bweb=0, done=0, overflow=0, words_written=0, state IDLE, FIFO empty.
- Latency from the 4th byte sampled at edge t to glb_wen high is 1 cycle: visible after edge t.
- in_ready is registered from the state and count after each edge.
- A back-to-back full-rate stream with glb_ready=1 sustains one word every 4 cycles without stall.
- Flush → done: at least 2 cycles (FLUSH then DONE) with the FIFO already empty.
- rst mid-tile discards the FIFO contents and the partial word immediately.

## Configuration
- PACKER_BYTE_MASK_EN defined:
  - The glb_bweb port exists.
  - Full words write with 4'b1111.
  - A flushed partial word with n valid bytes writes with (1<<n)-1, and its unused bytes are 0.
- PACKER_BYTE_MASK_EN undefined:
  - No glb_bweb port.
  - A partial word is zero-padded in its upper bytes and written as a full word.

## Test plan
- start with base_addr=0x100, bytes 01,02,03,04,05,06,07,08 on consecutive cycles, glb_ready=1 → writes 0x04030201@0x100 and 0x08070605@0x104; flush → done pulse; words_written=2.
- 6 bytes 11..16, then flush → second write is 0x00001615@0x104; with the macro, bweb=4'b0011.
- glb_ready=0 while 4*DEPTH bytes are streamed → in_ready drops when count reaches DEPTH-1. Forcing one further word → overflow=1 and exactly DEPTH words are written after glb_ready=1.
- glb_ready toggling 1/0 every cycle → glb_addr and glb_wdata stay stable during stalls and no word is duplicated or lost.
- rst asserted mid-tile with 2 words queued → all outputs return to reset values asynchronously, and no writes occur after release.
- base_addr=0xFFFFFFFC, 8 bytes → second write goes to address 0x00000000.

Source files
------------

// File: rtl/ppu_ofmap_packer.sv
// Packs the PPU byte stream little-endian into 32-bit words, queues them in a small FIFO
// and writes them to the GLB at consecutive byte addresses. Define PACKER_BYTE_MASK_EN for glb_bweb.
module ppu_ofmap_packer #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              flush,
  input  logic              i_valid,
  input  logic [7:0]        i_data,
  output logic              in_ready,
  output logic              glb_wen,
  output logic [ADDR_W-1:0] glb_addr,
  output logic [31:0]       glb_wdata,
`ifdef PACKER_BYTE_MASK_EN
  output logic [3:0]        glb_bweb,
`endif
  input  logic              glb_ready,
  output logic              done,
  output logic              overflow,
  output logic [15:0]       words_written
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] SLACK_C = CNT_W'(DEPTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PACK,
    S_FLUSH,
    S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [1:0]        idx_q, idx_d;
  logic [23:0]       part_q, part_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       ww_q, ww_d;
  logic              ovf_q, ovf_d;
  logic              in_ready_q, in_ready_d;
  logic [31:0]       mem_data_q [DEPTH];
`ifdef PACKER_BYTE_MASK_EN
  logic [3:0]        mem_mask_q [DEPTH];
  logic [3:0]        push_mask;
`endif

  logic        fifo_nempty;
  logic        pop;
  logic        has_space;
  logic        push;
  logic [31:0] push_data;

  assign fifo_nempty = (count_q != '0);
  assign pop         = fifo_nempty && glb_ready;
  // A full FIFO still takes a word when the head leaves in the same cycle.
  assign has_space   = (count_q < DEPTH_C) || pop;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    part_d    = part_q;
    addr_d    = addr_q;
    ww_d      = ww_q;
    ovf_d     = ovf_q;
    push      = 1'b0;
    push_data = '0;
`ifdef PACKER_BYTE_MASK_EN
    push_mask = '1;
`endif

    if (pop) begin
      addr_d = addr_q + ADDR_W'(4);
      if (ww_q != '1) begin
        ww_d = ww_q + 16'd1;
      end
    end

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_PACK;
          addr_d  = base_addr;
          idx_d   = '0;
          part_d  = '0;
          ww_d    = '0;
          ovf_d   = 1'b0;
        end
      end

      S_PACK: begin
        if (i_valid) begin
          idx_d = idx_q + 2'd1;
          // Byte 0 clears the upper bytes so a flushed partial word is zero-padded.
          unique case (idx_q)
            2'd0: part_d = {16'h0000, i_data};
            2'd1: part_d[15:8] = i_data;
            2'd2: part_d[23:16] = i_data;
            default: begin
              push_data = {i_data, part_q};
              if (has_space) begin
                push = 1'b1;
              end else begin
                ovf_d = 1'b1;
              end
            end
          endcase
        end
        if (flush) begin
          state_d = S_FLUSH;
        end
      end

      S_FLUSH: begin
        if (idx_q != 2'd0) begin
          if (has_space) begin
            push      = 1'b1;
            push_data = {8'h00, part_q};
            idx_d     = '0;
`ifdef PACKER_BYTE_MASK_EN
            unique case (idx_q)
              2'd1:    push_mask = 4'b0001;
              2'd2:    push_mask = 4'b0011;
              default: push_mask = 4'b0111;
            endcase
`endif
          end
        end else if (!fifo_nempty) begin
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    wr_ptr_d   = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d   = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d    = count_q + CNT_W'(push) - CNT_W'(pop);
    in_ready_d = (state_d == S_PACK) && (count_d < SLACK_C);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      idx_q      <= '0;
      part_q     <= '0;
      addr_q     <= '0;
      ww_q       <= '0;
      ovf_q      <= 1'b0;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      idx_q      <= idx_d;
      part_q     <= part_d;
      addr_q     <= addr_d;
      ww_q       <= ww_d;
      ovf_q      <= ovf_d;
      in_ready_q <= in_ready_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_data_q[wr_ptr_q] <= push_data;
`ifdef PACKER_BYTE_MASK_EN
      mem_mask_q[wr_ptr_q] <= push_mask;
`endif
    end
  end

  assign in_ready      = in_ready_q;
  assign glb_wen       = fifo_nempty;
  assign glb_addr      = addr_q;
  assign glb_wdata     = fifo_nempty ? mem_data_q[rd_ptr_q] : '0;
`ifdef PACKER_BYTE_MASK_EN
  assign glb_bweb      = fifo_nempty ? mem_mask_q[rd_ptr_q] : '0;
`endif
  assign done          = (state_q == S_DONE);
  assign overflow      = ovf_q;
  assign words_written = ww_q;

endmodule
